// File: rtl/vlsu.sv
// Vector load/store unit: splits a 32-byte vector access at any byte address
// into one or two 256-bit dmem line accesses and realigns load data.
module vlsu #(
    parameter int RD_LAT = 1  // dmem read latency in cycles; 1 or 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_wdata,
    output logic         req_ready,
    output logic         rsp_valid,
    output logic [255:0] rsp_rdata,
    output logic [31:0]  address_RAM,
    output logic [31:0]  byteena_RAM,
    output logic [255:0] writeData_RAM,
    input  logic [255:0] readData_RAM,
    output logic         rden_RAM,
    output logic         wren_RAM
);

    typedef enum logic [1:0] {IDLE, ACC_A, ACC_B, WAIT} state_t;

    state_t        r_state;
    logic          r_we;
    logic [26:0]   r_line_a;
    logic [4:0]    r_off;
    logic [255:0]  r_wdata;

    logic          r_rden;
    logic          r_wren;
    logic [31:0]   r_addr_ram;
    logic [31:0]   r_be;
    logic [255:0]  r_wd;

    logic [RD_LAT-1:0] r_rd_v;
    logic [RD_LAT-1:0] r_rd_b;
    logic [255:0]  r_line_a_q;
    logic [255:0]  r_line_b_q;
    logic          r_rsp_valid;
    logic [255:0]  r_rsp_rdata;

    logic [4:0]    w_off_in;
    logic [255:0]  w_wd_a_in;
    logic [31:0]   w_be_a_in;
    logic [26:0]   w_line_b;
    logic [8:0]    w_sh_b;
    logic [255:0]  w_wd_b;
    logic [31:0]   w_be_b;
    logic          w_cap;
    logic          w_cap_b;
    logic          w_cap_last;
    logic [255:0]  w_line_a_n;
    logic [255:0]  w_line_b_n;
    logic [255:0]  w_rsp;

    assign req_ready     = (r_state == IDLE) && !reset;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rden_RAM      = r_rden;
    assign wren_RAM      = r_wren;
    assign address_RAM   = r_addr_ram;
    assign byteena_RAM   = r_be;
    assign writeData_RAM = r_wd;

    // Line A fields come straight from the request so they can be registered at acceptance.
    assign w_off_in  = req_addr[4:0];
    assign w_wd_a_in = req_wdata << {w_off_in, 3'b000};
    assign w_be_a_in = 32'hFFFF_FFFF << w_off_in;

    // Line B holds the top o vector bytes in its low lanes; the line index wraps mod 2^27.
    assign w_line_b = r_line_a + 27'd1;
    assign w_sh_b   = 9'd256 - {1'b0, r_off, 3'b000};
    assign w_wd_b   = r_wdata >> w_sh_b;
    assign w_be_b   = (32'd1 << r_off) - 32'd1;

    // Read data arrives RD_LAT cycles after its strobe; the tag says which line it is.
    assign w_cap      = r_rd_v[RD_LAT-1];
    assign w_cap_b    = r_rd_b[RD_LAT-1];
    assign w_cap_last = w_cap && (w_cap_b || (r_off == 5'd0));
    assign w_line_a_n = (w_cap && !w_cap_b) ? readData_RAM : r_line_a_q;
    assign w_line_b_n = (w_cap &&  w_cap_b) ? readData_RAM : r_line_b_q;
    assign w_rsp      = (w_line_a_n >> {r_off, 3'b000})
                      | ((r_off != 5'd0) ? (w_line_b_n << w_sh_b) : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_line_a    <= '0;
            r_off       <= '0;
            r_wdata     <= '0;
            r_rden      <= 1'b0;
            r_wren      <= 1'b0;
            r_addr_ram  <= '0;
            r_be        <= '0;
            r_wd        <= '0;
            r_rd_v      <= '0;
            r_rd_b      <= '0;
            r_line_a_q  <= '0;
            r_line_b_q  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // NOTE: every dmem field falls back to 0 each cycle, so an access state
            // produces exactly one strobe cycle and the bus is quiet elsewhere.
            r_rden      <= 1'b0;
            r_wren      <= 1'b0;
            r_addr_ram  <= '0;
            r_be        <= '0;
            r_wd        <= '0;
            r_rsp_valid <= 1'b0;

            r_rd_v[0] <= r_rden;
            r_rd_b[0] <= (r_state == ACC_B);
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_v[i] <= r_rd_v[i-1];
                r_rd_b[i] <= r_rd_b[i-1];
            end

            if (w_cap) begin
                if (w_cap_b) r_line_b_q <= readData_RAM;
                else         r_line_a_q <= readData_RAM;
            end

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state    <= ACC_A;
                        r_we       <= req_we;
                        r_line_a   <= req_addr[31:5];
                        r_off      <= w_off_in;
                        r_wdata    <= req_wdata;
                        r_addr_ram <= {5'b0, req_addr[31:5]};
                        if (req_we) begin
                            r_wren <= 1'b1;
                            r_wd   <= w_wd_a_in;
                            r_be   <= w_be_a_in;
                        end else begin
                            r_rden <= 1'b1;
                            r_be   <= 32'hFFFF_FFFF;
                        end
                    end
                end
                ACC_A: begin
                    if (r_off != 5'd0) begin
                        r_state    <= ACC_B;
                        r_addr_ram <= {5'b0, w_line_b};
                        if (r_we) begin
                            r_wren <= 1'b1;
                            r_wd   <= w_wd_b;
                            r_be   <= w_be_b;
                        end else begin
                            r_rden <= 1'b1;
                            r_be   <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        r_state <= r_we ? IDLE : WAIT;
                    end
                end
                ACC_B: begin
                    r_state <= r_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (w_cap_last) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vlsu.sv
// Bench for vlsu: one instance per legal read latency, each with a behavioural
// dmem; expected dmem beats and load responses are queued and checked on arrival.
`timescale 1ns/1ps
module tb_vlsu;

    localparam int N = 2;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   be;
        logic [255:0]  data;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [255:0]  rdata;
        int            cyc;
    } rsp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid [N];
    logic         req_we;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         req_ready [N];
    logic         rsp_valid [N];
    logic [255:0] rsp_rdata [N];
    logic [31:0]  address_RAM [N];
    logic [31:0]  byteena_RAM [N];
    logic [255:0] writeData_RAM [N];
    logic [255:0] readData_RAM [N];
    logic         rden_RAM [N];
    logic         wren_RAM [N];

    logic [255:0] mem [N][8];
    logic [255:0] rd_s1 [N];
    logic [255:0] rd_s2 [N];
    logic [7:0]   ref_b [256];

    beat_t beat_q [N][$];
    rsp_t  rsp_q  [N][$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [255:0] pat_p, pat_p1, pat_p2;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        vlsu #(.RD_LAT(gi + 1)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .req_valid     (req_valid[gi]),
            .req_we        (req_we),
            .req_addr      (req_addr),
            .req_wdata     (req_wdata),
            .req_ready     (req_ready[gi]),
            .rsp_valid     (rsp_valid[gi]),
            .rsp_rdata     (rsp_rdata[gi]),
            .address_RAM   (address_RAM[gi]),
            .byteena_RAM   (byteena_RAM[gi]),
            .writeData_RAM (writeData_RAM[gi]),
            .readData_RAM  (readData_RAM[gi]),
            .rden_RAM      (rden_RAM[gi]),
            .wren_RAM      (wren_RAM[gi])
        );
        assign readData_RAM[gi] = (gi == 0) ? rd_s1[gi] : rd_s2[gi];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // dmem: 8 lines selected by address bits [2:0], junk on the read bus when not reading
    always @(posedge clk) begin
        for (int m = 0; m < N; m++) begin
            if (cyc == 0)
                for (int l = 0; l < 8; l++)
                    for (int b = 0; b < 32; b++) mem[m][l][8*b +: 8] = ref_b[32*l + b];
            rd_s1[m] <= rden_RAM[m] ? mem[m][address_RAM[m][2:0]] : {8{32'hDEAD_BEEF}};
            rd_s2[m] <= rd_s1[m];
            if (wren_RAM[m])
                for (int b = 0; b < 32; b++)
                    if (byteena_RAM[m][b])
                        mem[m][address_RAM[m][2:0]][8*b +: 8] = writeData_RAM[m][8*b +: 8];
        end
        cyc++;
    end

    always @(negedge clk) begin
        beat_t eb;
        rsp_t  er;
        for (int m = 0; m < N; m++) begin
            if (wren_RAM[m] || rden_RAM[m]) begin
                if (beat_q[m].size() == 0) begin
                    check($sformatf("i%0d_extra_beat", m), {254'd0, wren_RAM[m], rden_RAM[m]}, '0);
                end else begin
                    eb = beat_q[m].pop_front();
                    check($sformatf("i%0d_beat_cycle", m), cyc, eb.cyc);
                    check($sformatf("i%0d_beat_wren", m), wren_RAM[m], eb.wr);
                    check($sformatf("i%0d_beat_rden", m), rden_RAM[m], !eb.wr);
                    check($sformatf("i%0d_beat_addr", m), address_RAM[m], eb.addr);
                    check($sformatf("i%0d_beat_be", m), byteena_RAM[m], eb.be);
                    if (eb.wr) check($sformatf("i%0d_beat_wdata", m), writeData_RAM[m], eb.data);
                end
            end
            if (rsp_valid[m]) begin
                if (rsp_q[m].size() == 0) begin
                    check($sformatf("i%0d_extra_rsp", m), rsp_valid[m], 1'b0);
                end else begin
                    er = rsp_q[m].pop_front();
                    check($sformatf("i%0d_rsp_cycle", m), cyc, er.cyc);
                    check($sformatf("i%0d_rsp_rdata", m), rsp_rdata[m], er.rdata);
                end
            end
        end
    end

    // Byte-level model: each vector byte i lands at byte address addr+i.
    task automatic push_req(input int mask, input logic we, input logic [31:0] addr,
                            input logic [255:0] wdata, input bit cut);
        beat_t ba, bb;
        rsp_t  r;
        bit    has_b;
        logic [31:0] a;
        logic [26:0] la;
        la = addr[31:5];
        ba.wr = we; ba.addr = {5'b0, la}; ba.be = '0; ba.data = '0; ba.cyc = cyc + 1;
        bb.wr = we; bb.addr = '0;         bb.be = '0; bb.data = '0; bb.cyc = cyc + 2;
        r.rdata = '0;
        has_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a = addr + i;
            r.rdata[8*i +: 8] = ref_b[a[7:0]];
            if (a[31:5] == la) begin
                ba.be[a[4:0]] = 1'b1;
                ba.data[8*a[4:0] +: 8] = wdata[8*i +: 8];
            end else begin
                has_b = 1'b1;
                bb.addr = {5'b0, a[31:5]};
                bb.be[a[4:0]] = 1'b1;
                bb.data[8*a[4:0] +: 8] = wdata[8*i +: 8];
            end
            if (we && (a[31:5] == la || !cut)) ref_b[a[7:0]] = wdata[8*i +: 8];
        end
        if (!we) begin
            ba.be = 32'hFFFF_FFFF;
            bb.be = 32'hFFFF_FFFF;
        end
        for (int m = 0; m < N; m++) begin
            if (mask[m]) begin
                beat_q[m].push_back(ba);
                if (has_b && !cut) beat_q[m].push_back(bb);
                if (!we && !cut) begin
                    r.cyc = cyc + 2 + (m + 1) + (has_b ? 1 : 0);
                    rsp_q[m].push_back(r);
                end
            end
        end
    endtask

    // Called at the negedge of the acceptance cycle; returns at the next negedge.
    task automatic do_req(input int mask, input logic we, input logic [31:0] addr,
                          input logic [255:0] wdata, input bit cut);
        for (int m = 0; m < N; m++)
            if (mask[m]) check($sformatf("i%0d_ready_at_req", m), req_ready[m], 1'b1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        for (int m = 0; m < N; m++) req_valid[m] = mask[m];
        push_req(mask, we, addr, wdata, cut);
        @(negedge clk);
        for (int m = 0; m < N; m++) req_valid[m] = 1'b0;
    endtask

    task automatic wait_ready(input int mask);
        for (int k = 0; k < 64; k++) begin
            if ((!mask[0] || req_ready[0]) && (!mask[1] || req_ready[1])) break;
            @(negedge clk);
        end
        for (int m = 0; m < N; m++)
            if (mask[m]) check($sformatf("i%0d_ready_wait", m), req_ready[m], 1'b1);
    endtask

    task automatic check_ready(input string tag, input logic exp);
        for (int m = 0; m < N; m++) check($sformatf("i%0d_%s", m, tag), req_ready[m], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] got;
        logic [31:0]  a;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            pat_p [32*i +: 32] = $urandom;
            pat_p1[32*i +: 32] = $urandom;
            pat_p2[32*i +: 32] = $urandom;
        end
        for (int m = 0; m < N; m++) req_valid[m] = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;

        repeat (3) @(negedge clk);
        for (int m = 0; m < N; m++) begin
            check($sformatf("i%0d_rst_ready", m), req_ready[m], 1'b0);
            check($sformatf("i%0d_rst_rsp_valid", m), rsp_valid[m], 1'b0);
            check($sformatf("i%0d_rst_rsp_rdata", m), rsp_rdata[m], '0);
            check($sformatf("i%0d_rst_wren", m), wren_RAM[m], 1'b0);
            check($sformatf("i%0d_rst_rden", m), rden_RAM[m], 1'b0);
            check($sformatf("i%0d_rst_addr", m), address_RAM[m], '0);
            check($sformatf("i%0d_rst_be", m), byteena_RAM[m], '0);
            check($sformatf("i%0d_rst_wdata", m), writeData_RAM[m], '0);
        end
        reset = 1'b0;
        @(negedge clk);

        // aligned store: one beat, ready back at C+2
        do_req(3, 1'b1, 32'h40, pat_p1, 1'b0);
        check_ready("st_al_c1", 1'b0);
        @(negedge clk);
        check_ready("st_al_c2", 1'b1);

        // unaligned store with req_valid held high while busy
        do_req(3, 1'b1, 32'h25, pat_p, 1'b0);
        for (int m = 0; m < N; m++) req_valid[m] = 1'b1;
        req_we = 1'b0; req_addr = 32'h80;
        check_ready("st_un_c1", 1'b0);
        @(negedge clk);
        check_ready("st_un_c2", 1'b0);
        for (int m = 0; m < N; m++) req_valid[m] = 1'b0;
        @(negedge clk);
        check_ready("st_un_c3", 1'b1);

        // unaligned load of the stored vector
        do_req(3, 1'b0, 32'h25, '0, 1'b0);
        wait_ready(3);

        // aligned load, then back-to-back request in the rsp_valid cycle
        do_req(3, 1'b0, 32'h40, '0, 1'b0);
        for (int k = 0; k < 16 && !rsp_valid[0]; k++) @(negedge clk);
        check("b2b_rsp_seen", rsp_valid[0], 1'b1);
        do_req(1, 1'b0, 32'h25, '0, 1'b0);
        wait_ready(3);

        // line index wrap
        do_req(3, 1'b0, 32'hFFFF_FFF0, '0, 1'b0);
        wait_ready(3);

        // reset during an unaligned store: second beat must not appear
        do_req(3, 1'b1, 32'h6A, pat_p2, 1'b1);
        #2 reset = 1'b1;
        @(negedge clk);
        for (int m = 0; m < N; m++) check($sformatf("i%0d_rst_st_no_wren", m), wren_RAM[m], 1'b0);
        check_ready("rst_st_busy", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_ready("rst_st_after", 1'b1);

        // reset during an unaligned load: no response may appear
        do_req(3, 1'b0, 32'h8B, '0, 1'b1);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_ready("rst_ld_after", 1'b1);

        // read back the half-written vector
        do_req(3, 1'b0, 32'h6A, '0, 1'b0);
        wait_ready(3);

        repeat (8) @(negedge clk);
        for (int m = 0; m < N; m++) begin
            got = '0;
            for (int i = 0; i < 32; i++) begin
                a = 32'h25 + i;
                got[8*i +: 8] = mem[m][a[7:5]][8*a[4:0] +: 8];
            end
            check($sformatf("i%0d_dmem_bytes_25_44", m), got, pat_p);
            check($sformatf("i%0d_beats_left", m), beat_q[m].size(), '0);
            check($sformatf("i%0d_rsps_left", m), rsp_q[m].size(), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
